// File: rtl/pool_pkg.sv
// -----------------------------------------------------------------------------
// pool_pkg
// Shared constants and types for the 2x2 RGB444 average-pooling block.
//   PIX_W   : RGB444 pixel width
//   CH_W    : single colour channel width
//   PAIR_W  : width of a two-pixel channel sum
//   SUM_W   : width of a four-pixel channel sum
//   R_/G_/B_HI/LO : channel slice bounds inside a pixel
//   LB_W    : line buffer entry width (three packed pair sums)
//   row_state_t, EVEN_ROW, ODD_ROW : row-phase FSM encoding
// -----------------------------------------------------------------------------
package pool_pkg;

  localparam int PIX_W  = 12;
  localparam int CH_W   = 4;
  localparam int PAIR_W = 5;
  localparam int SUM_W  = 6;

  localparam int R_HI = 11;
  localparam int R_LO = 8;
  localparam int G_HI = 7;
  localparam int G_LO = 4;
  localparam int B_HI = 3;
  localparam int B_LO = 0;

  localparam int LB_W = 3 * PAIR_W;

  typedef logic [0:0] row_state_t;
  localparam row_state_t EVEN_ROW = 1'b0;
  localparam row_state_t ODD_ROW  = 1'b1;

  // Zero-extended sum of two channel values.
  function automatic logic [PAIR_W-1:0] pair_sum(input logic [CH_W-1:0] a,
                                                 input logic [CH_W-1:0] b);
    return {1'b0, a} + {1'b0, b};
  endfunction

endpackage

// File: rtl/pool_line_buf.sv
// -----------------------------------------------------------------------------
// pool_line_buf
// Holds the per-channel pair sums of the even row, one entry per output column.
//   clk   : clock
//   we    : write enable
//   waddr : write address (output column)
//   wdata : packed {R,G,B} pair sums, PAIR_W bits each
//   raddr : read address (output column)
//   rdata : asynchronous read data
// -----------------------------------------------------------------------------
module pool_line_buf
  import pool_pkg::*;
#(
  parameter int DEPTH  = 10,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [LB_W-1:0]   wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [LB_W-1:0]   rdata
);

  logic [LB_W-1:0] mem [DEPTH];

  // NOTE: storage arrays get no reset; every entry is written on the even row
  // before the odd row reads it, and a reset port would block RAM mapping.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/pool2x2_downsample.sv
// -----------------------------------------------------------------------------
// pool2x2_downsample
// Averages each non-overlapping 2x2 block of an RGB444 raster frame into one
// output pixel, with valid/ready handshakes on both sides.
//   clk        : clock, rising edge
//   reset      : asynchronous active-high reset
//   pixel_in   : RGB444 input pixel, R[11:8] G[7:4] B[3:0]
//   in_valid   : pixel_in is valid
//   in_ready   : block can accept a pixel
//   pixel_out  : averaged RGB444 pixel (registered)
//   out_valid  : pixel_out is valid
//   out_ready  : downstream accepts pixel_out
//   frame_done : one-cycle pulse after the last pixel of a frame is accepted
// Build option: define POOL_ROUND_EN to round half up instead of truncating.
// -----------------------------------------------------------------------------
module pool2x2_downsample
  import pool_pkg::*;
#(
  parameter int IN_ROWS = 20,
  parameter int IN_COLS = 20
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [PIX_W-1:0] pixel_in,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [PIX_W-1:0] pixel_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             frame_done
);

  localparam int COL_W  = (IN_COLS > 1) ? $clog2(IN_COLS) : 1;
  localparam int ROW_W  = (IN_ROWS > 1) ? $clog2(IN_ROWS) : 1;
  localparam int DEPTH  = IN_COLS / 2;
  localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  if (IN_ROWS % 2 != 0) begin : g_rows_odd
    $error("pool2x2_downsample: IN_ROWS must be even");
  end
  if (IN_COLS % 2 != 0) begin : g_cols_odd
    $error("pool2x2_downsample: IN_COLS must be even");
  end

  logic [COL_W-1:0]  col;
  logic [ROW_W-1:0]  row;
  row_state_t        state;
  logic [PIX_W-1:0]  held;

  logic              in_fire;
  logic              col_last;
  logic              row_last;
  logic              complete;
  logic              lb_we;
  logic [ADDR_W-1:0] lb_addr;
  logic [LB_W-1:0]   lb_wdata;
  logic [LB_W-1:0]   lb_rdata;
  logic [PIX_W-1:0]  result;

  // Four-pixel channel average from an even-row pair sum plus two odd-row values.
  function automatic logic [CH_W-1:0] avg_channel(input logic [PAIR_W-1:0] pair,
                                                  input logic [CH_W-1:0]   a,
                                                  input logic [CH_W-1:0]   b);
    logic [SUM_W-1:0] total;
`ifdef POOL_ROUND_EN
    logic [SUM_W:0]   rounded;
`endif
    total = SUM_W'(pair) + SUM_W'(a) + SUM_W'(b);
`ifdef POOL_ROUND_EN
    rounded = {1'b0, total} + (SUM_W+1)'(2);
    return rounded[5:2];
`else
    return total[5:2];
`endif
  endfunction

  // A stalled output blocks input only while downstream is not taking it.
  assign in_ready = !out_valid || out_ready;
  assign in_fire  = in_valid && in_ready;
  assign col_last = (col == COL_W'(IN_COLS - 1));
  assign row_last = (row == ROW_W'(IN_ROWS - 1));
  assign lb_addr  = ADDR_W'(col >> 1);

  // Odd column of an even row stores the pair sum; odd column of an odd row
  // completes a 2x2 block.
  assign lb_we    = in_fire && (state == EVEN_ROW) && col[0];
  assign complete = in_fire && (state == ODD_ROW) && col[0];

  assign lb_wdata = {pair_sum(held[R_HI:R_LO], pixel_in[R_HI:R_LO]),
                     pair_sum(held[G_HI:G_LO], pixel_in[G_HI:G_LO]),
                     pair_sum(held[B_HI:B_LO], pixel_in[B_HI:B_LO])};

  assign result = {avg_channel(lb_rdata[3*PAIR_W-1:2*PAIR_W], held[R_HI:R_LO], pixel_in[R_HI:R_LO]),
                   avg_channel(lb_rdata[2*PAIR_W-1:PAIR_W],   held[G_HI:G_LO], pixel_in[G_HI:G_LO]),
                   avg_channel(lb_rdata[PAIR_W-1:0],          held[B_HI:B_LO], pixel_in[B_HI:B_LO])};

  pool_line_buf #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_line_buf (
    .clk   (clk),
    .we    (lb_we),
    .waddr (lb_addr),
    .wdata (lb_wdata),
    .raddr (lb_addr),
    .rdata (lb_rdata)
  );

  // NOTE: registers are updated with non-blocking assignments so every read in
  // this block sees the pre-edge value, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col        <= '0;
      row        <= '0;
      state      <= EVEN_ROW;
      held       <= '0;
      pixel_out  <= '0;
      out_valid  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= in_fire && col_last && row_last;

      if (in_fire) begin
        if (!col[0]) held <= pixel_in;
        if (col_last) begin
          col   <= '0;
          state <= (state == EVEN_ROW) ? ODD_ROW : EVEN_ROW;
          row   <= row_last ? '0 : row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end

      // A new result wins over a same-cycle output transfer.
      if (complete) begin
        pixel_out <= result;
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pool2x2_downsample.sv
// -----------------------------------------------------------------------------
// tb_pool2x2_downsample
// Directed and randomised-handshake bench for pool2x2_downsample (20x20 frame).
// Build option: define POOL_ROUND_EN to match a rounding build of the design.
// -----------------------------------------------------------------------------
module tb_pool2x2_downsample;

  localparam int R  = 20;
  localparam int C  = 20;
  localparam int NO = (R / 2) * (C / 2);

`ifdef POOL_ROUND_EN
  localparam logic [11:0] TL_EXP = 12'h002;
`else
  localparam logic [11:0] TL_EXP = 12'h001;
`endif

  logic        clk;
  logic        reset;
  logic [11:0] pixel_in;
  logic        in_valid;
  logic        in_ready;
  logic [11:0] pixel_out;
  logic        out_valid;
  logic        out_ready;
  logic        frame_done;

  logic [11:0] src_q[$];
  logic [11:0] exp_q[$];
  logic [11:0] got_q[$];
  int          fd_seen;
  int          pass_cnt;
  int          chk_cnt;

  pool2x2_downsample #(
    .IN_ROWS (R),
    .IN_COLS (C)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .pixel_in   (pixel_in),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .pixel_out  (pixel_out),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: direct four-pixel channel average of each 2x2 block.
  function automatic void build_expected();
    int nf;
    int base;
    int sum;
    int res;
    exp_q.delete();
    nf = src_q.size() / (R * C);
    for (int f = 0; f < nf; f++)
      for (int br = 0; br < R / 2; br++)
        for (int bc = 0; bc < C / 2; bc++) begin
          res = 0;
          for (int ch = 0; ch < 3; ch++) begin
            sum = 0;
            for (int dr = 0; dr < 2; dr++)
              for (int dc = 0; dc < 2; dc++) begin
                base = f * R * C + (2 * br + dr) * C + 2 * bc + dc;
                sum += (int'(src_q[base]) >> (4 * ch)) & 15;
              end
`ifdef POOL_ROUND_EN
            sum += 2;
`endif
            res |= (sum / 4) << (4 * ch);
          end
          exp_q.push_back(12'(res));
        end
  endfunction

  function automatic int stream_errors();
    int n = 0;
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      if (got_q[i] !== exp_q[i]) n++;
    return n;
  endfunction

  task automatic fill_frame(input logic [11:0] v);
    for (int i = 0; i < R * C; i++) src_q.push_back(v);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // Sends src_q[first..last-1] and collects outputs until n_out have arrived.
  task automatic run_stream(input int first, input int last, input int vpct,
                            input int rpct, input int n_out, input string name);
    int sent   = first;
    int cycles = 0;
    while ((sent < last || got_q.size() < n_out) && cycles < 20000) begin
      @(negedge clk);
      in_valid  = (sent < last) && ($urandom_range(99) < vpct);
      pixel_in  = in_valid ? src_q[sent] : 12'($urandom);
      out_ready = ($urandom_range(99) < rpct);
      #1;
      if (in_valid && in_ready) sent++;
      if (out_valid && out_ready) got_q.push_back(pixel_out);
      if (frame_done) fd_seen++;
      cycles++;
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    chk_cnt++;
    if (cycles >= 20000)
      $display("FAIL %s_timeout: cycles=%0d sent=%0d outputs=%0d", name, cycles, sent, got_q.size());
    else pass_cnt++;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk_cnt++;
    if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid);
    else pass_cnt++;
    chk_cnt++;
    if (pixel_out !== 12'h000) $display("FAIL reset_pixel_out: got %h want 000", pixel_out);
    else pass_cnt++;
    chk_cnt++;
    if (frame_done !== 1'b0) $display("FAIL reset_frame_done: got %b want 0", frame_done);
    else pass_cnt++;
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk_cnt++;
    if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready);
    else pass_cnt++;
  endtask

  task automatic test_uniform();
    int bad = 0;
    src_q.delete(); got_q.delete(); fd_seen = 0;
    fill_frame(12'hABC);
    run_stream(0, R * C, 100, 100, NO, "uniform");
    for (int i = 0; i < got_q.size(); i++) if (got_q[i] !== 12'hABC) bad++;
    chk_cnt++;
    if (got_q.size() !== NO) $display("FAIL uniform_count: got %0d want %0d", got_q.size(), NO);
    else pass_cnt++;
    chk_cnt++;
    if (bad !== 0) $display("FAIL uniform_values: %0d outputs differ from ABC", bad);
    else pass_cnt++;
    chk_cnt++;
    if (fd_seen !== 1) $display("FAIL uniform_frame_done: got %0d want 1", fd_seen);
    else pass_cnt++;
  endtask

  task automatic test_top_left();
    logic [11:0] first_out;
    src_q.delete(); got_q.delete(); fd_seen = 0;
    fill_frame(12'h000);
    src_q[1]     = 12'h001;
    src_q[C]     = 12'h002;
    src_q[C + 1] = 12'h003;
    build_expected();
    run_stream(0, R * C, 100, 100, NO, "top_left");
    first_out = (got_q.size() > 0) ? got_q[0] : 12'hxxx;
    chk_cnt++;
    if (first_out !== TL_EXP) $display("FAIL top_left_first: got %h want %h", first_out, TL_EXP);
    else pass_cnt++;
    chk_cnt++;
    if (got_q.size() !== NO) $display("FAIL top_left_count: got %0d want %0d", got_q.size(), NO);
    else pass_cnt++;
    chk_cnt++;
    if (stream_errors() !== 0) $display("FAIL top_left_stream: %0d outputs differ from model", stream_errors());
    else pass_cnt++;
  endtask

  task automatic test_saturate();
    int bad = 0;
    src_q.delete(); got_q.delete(); fd_seen = 0;
    fill_frame(12'hFFF);
    run_stream(0, R * C, 100, 100, NO, "saturate");
    for (int i = 0; i < got_q.size(); i++) if (got_q[i] !== 12'hFFF) bad++;
    chk_cnt++;
    if (got_q.size() !== NO) $display("FAIL saturate_count: got %0d want %0d", got_q.size(), NO);
    else pass_cnt++;
    chk_cnt++;
    if (bad !== 0) $display("FAIL saturate_values: %0d outputs differ from FFF", bad);
    else pass_cnt++;
  endtask

  task automatic test_backpressure();
    src_q.delete(); got_q.delete(); fd_seen = 0;
    for (int i = 0; i < R * C; i++) src_q.push_back(12'((i * 37 + 5) ^ (i << 5)));
    build_expected();
    // Pixel index C+1 completes the first block; downstream is not ready.
    run_stream(0, C + 2, 100, 0, 0, "bp_fill");
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      in_valid  = 1'b1;
      pixel_in  = src_q[C + 2];
      out_ready = 1'b0;
      #1;
      chk_cnt++;
      if (out_valid !== 1'b1) $display("FAIL bp_out_valid[%0d]: got %b want 1", k, out_valid);
      else pass_cnt++;
      chk_cnt++;
      if (in_ready !== 1'b0) $display("FAIL bp_in_ready[%0d]: got %b want 0", k, in_ready);
      else pass_cnt++;
      chk_cnt++;
      if (pixel_out !== exp_q[0]) $display("FAIL bp_hold[%0d]: got %h want %h", k, pixel_out, exp_q[0]);
      else pass_cnt++;
    end
    run_stream(C + 2, R * C, 100, 100, NO, "bp_drain");
    chk_cnt++;
    if (got_q.size() !== NO) $display("FAIL bp_count: got %0d want %0d", got_q.size(), NO);
    else pass_cnt++;
    chk_cnt++;
    if (stream_errors() !== 0) $display("FAIL bp_stream: %0d outputs differ from model", stream_errors());
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    int bad   = 0;
    int extra = 0;
    src_q.delete(); got_q.delete(); fd_seen = 0;
    for (int i = 0; i < 50; i++) src_q.push_back(12'(i * 91 + 7));
    run_stream(0, 50, 100, 100, 0, "mid_partial");
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk_cnt++;
    if (out_valid !== 1'b0) $display("FAIL mid_reset_out_valid: got %b want 0", out_valid);
    else pass_cnt++;
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk_cnt++;
    if (out_valid !== 1'b0) $display("FAIL mid_after_out_valid: got %b want 0", out_valid);
    else pass_cnt++;
    src_q.delete(); got_q.delete(); fd_seen = 0;
    fill_frame(12'h123);
    run_stream(0, R * C, 100, 100, NO, "mid_frame");
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      out_ready = 1'b1;
      #1;
      if (out_valid) extra++;
    end
    out_ready = 1'b0;
    for (int i = 0; i < got_q.size(); i++) if (got_q[i] !== 12'h123) bad++;
    chk_cnt++;
    if (got_q.size() + extra !== NO) $display("FAIL mid_count: got %0d want %0d", got_q.size() + extra, NO);
    else pass_cnt++;
    chk_cnt++;
    if (bad !== 0) $display("FAIL mid_values: %0d outputs differ from 123", bad);
    else pass_cnt++;
    chk_cnt++;
    if (fd_seen !== 1) $display("FAIL mid_frame_done: got %0d want 1", fd_seen);
    else pass_cnt++;
  endtask

  task automatic test_random();
    src_q.delete(); got_q.delete(); fd_seen = 0;
    for (int i = 0; i < 3 * R * C; i++) src_q.push_back(12'($urandom));
    build_expected();
    run_stream(0, 3 * R * C, 70, 60, 3 * NO, "random");
    chk_cnt++;
    if (got_q.size() !== 3 * NO) $display("FAIL random_count: got %0d want %0d", got_q.size(), 3 * NO);
    else pass_cnt++;
    chk_cnt++;
    if (stream_errors() !== 0) $display("FAIL random_stream: %0d outputs differ from model", stream_errors());
    else pass_cnt++;
    chk_cnt++;
    if (fd_seen !== 3) $display("FAIL random_frame_done: got %0d want 3", fd_seen);
    else pass_cnt++;
  endtask

  initial begin
    pass_cnt  = 0;
    chk_cnt   = 0;
    fd_seen   = 0;
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    pixel_in  = 12'h000;
    apply_reset();
    test_reset();
    test_uniform();
    test_top_left();
    test_saturate();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
